// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Run-time programmable UART baud tick generator. Each channel (TX, RX) runs
// its own fractional divider: a period counter whose length is stretched by
// one cycle whenever the fraction accumulator carries. Every OSR periods make
// one bit. TX gets a strobe at the start of each bit. RX gets the oversample
// tick plus a mid-bit strobe. New divisors are staged in a shadow register
// and copied to the active divisor only while both channels are idle.

module uart_baud_gen #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned OSR    = 16,
  parameter int          DIV_W  = 16,
  parameter int          FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_clk_en,
  input  logic              rx_clk_en,
  input  logic [DIV_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              cfg_load,
  output logic              cfg_pending,
  output logic              tx_clk,
  output logic              rx_clk,
  output logic              rx_os_tick
);

  localparam int PH_W = $clog2(OSR);

  // Reset-default divisor: integer and fractional part of CLK_HZ/(BAUD*OSR).
  localparam logic [63:0] TICK_HZ     = 64'(BAUD) * 64'(OSR);
  localparam logic [63:0] DEF_INT_64  = 64'(CLK_HZ) / TICK_HZ;
  localparam logic [63:0] DEF_FRAC_64 = ((64'(CLK_HZ) << FRAC_W) / TICK_HZ) % (64'd1 << FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_INT_64);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_FRAC_64);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OSR / 2 - 1);

  // ---------------------------------------------------------------------------
  // Configuration: shadow, active divisor, pending flag
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  cfg_int_clamped;
  logic              both_idle;
  logic              apply_cfg;

  // Clamp tiny divisors so every strobe is followed by at least one low cycle.
  always_comb begin
    cfg_int_clamped = (cfg_int < DIV_W'(2)) ? DIV_W'(2) : cfg_int;
    both_idle       = !tx_clk_en && !rx_clk_en;
    apply_cfg       = cfg_pending && both_idle;
  end

  // Shadow register: last cfg_load wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_int  <= DEF_INT;
      sh_frac <= DEF_FRAC;
    end else if (cfg_load) begin
      sh_int  <= cfg_int_clamped;
      sh_frac <= cfg_frac;
    end
  end

  // Active divisor: only updated from the shadow while both channels are idle,
  // so a frame in flight never sees a divisor change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int  <= DEF_INT;
      act_frac <= DEF_FRAC;
    end else if (apply_cfg) begin
      act_int  <= sh_int;
      act_frac <= sh_frac;
    end
  end

  // Pending flag: a load in the same cycle as a transfer keeps it set, because
  // the transfer took the old shadow and the new value still has to be applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pending <= 1'b0;
    end else if (cfg_load) begin
      cfg_pending <= 1'b1;
    end else if (apply_cfg) begin
      cfg_pending <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX channel
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]  tx_cnt;
  logic [FRAC_W-1:0] tx_acc;
  logic [PH_W-1:0]   tx_ph;
  logic [FRAC_W:0]   tx_acc_sum;
  logic [DIV_W:0]    tx_len;
  logic [DIV_W:0]    tx_last;
  logic              tx_os;

  // TX period length: one extra cycle whenever the accumulator carries.
  always_comb begin
    tx_acc_sum = {1'b0, tx_acc} + {1'b0, act_frac};
    tx_len     = {1'b0, act_int} + {{DIV_W{1'b0}}, tx_acc_sum[FRAC_W]};
    tx_last    = tx_len - (DIV_W + 1)'(1);
    tx_os      = tx_clk_en && ({1'b0, tx_cnt} == tx_last);
  end

  // TX counters: held at zero while disabled so the next enable starts a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      tx_acc <= '0;
      tx_ph  <= '0;
    end else if (!tx_clk_en) begin
      tx_cnt <= '0;
      tx_acc <= '0;
      tx_ph  <= '0;
    end else if (tx_os) begin
      tx_cnt <= '0;
      tx_acc <= tx_acc_sum[FRAC_W-1:0];
      tx_ph  <= (tx_ph == PH_LAST) ? '0 : tx_ph + PH_W'(1);
    end else begin
      tx_cnt <= tx_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // RX channel
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]  rx_cnt;
  logic [FRAC_W-1:0] rx_acc;
  logic [PH_W-1:0]   rx_ph;
  logic [FRAC_W:0]   rx_acc_sum;
  logic [DIV_W:0]    rx_len;
  logic [DIV_W:0]    rx_last;
  logic              rx_os;

  // RX period length: one extra cycle whenever the accumulator carries.
  always_comb begin
    rx_acc_sum = {1'b0, rx_acc} + {1'b0, act_frac};
    rx_len     = {1'b0, act_int} + {{DIV_W{1'b0}}, rx_acc_sum[FRAC_W]};
    rx_last    = rx_len - (DIV_W + 1)'(1);
    rx_os      = rx_clk_en && ({1'b0, rx_cnt} == rx_last);
  end

  // RX counters: held at zero while disabled so the next enable starts a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt <= '0;
      rx_acc <= '0;
      rx_ph  <= '0;
    end else if (!rx_clk_en) begin
      rx_cnt <= '0;
      rx_acc <= '0;
      rx_ph  <= '0;
    end else if (rx_os) begin
      rx_cnt <= '0;
      rx_acc <= rx_acc_sum[FRAC_W-1:0];
      rx_ph  <= (rx_ph == PH_LAST) ? '0 : rx_ph + PH_W'(1);
    end else begin
      rx_cnt <= rx_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Strobes
  // ---------------------------------------------------------------------------
  // Combinational decodes of the counter state. They are gated by rst_n so that
  // they drop the instant reset asserts, even while an enable is still high.
  always_comb begin
    tx_clk     = rst_n && tx_clk_en && (tx_cnt == '0) && (tx_ph == '0);
    rx_os_tick = rst_n && rx_os;
    rx_clk     = rst_n && rx_os && (rx_ph == PH_MID);
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen. The stimulus process predicts strobe cycles from
// closed-form period sums and queues them. A negedge monitor pops and compares
// these predictions against the strobes it sees.
module tb_uart_baud_gen;
  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 9600;
  localparam int unsigned OSR    = 16;
  localparam int          DIV_W  = 16;
  localparam int          FRAC_W = 4;

  localparam longint DEF_I = longint'(CLK_HZ) / (longint'(BAUD) * longint'(OSR));
  localparam longint DEF_F = ((longint'(CLK_HZ) * (longint'(1) << FRAC_W)) /
                              (longint'(BAUD) * longint'(OSR))) % (longint'(1) << FRAC_W);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tx_clk_en = 1'b0;
  logic              rx_clk_en = 1'b0;
  logic [DIV_W-1:0]  cfg_int = '0;
  logic [FRAC_W-1:0] cfg_frac = '0;
  logic              cfg_load = 1'b0;
  logic              cfg_pending;
  logic              tx_clk;
  logic              rx_clk;
  logic              rx_os_tick;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  bit     mon_en = 1'b0;

  longint q_tx[$];
  longint q_os[$];
  longint q_rx[$];

  // reference divisor state
  longint m_int, m_frac, m_sh_int, m_sh_frac;
  bit     m_pend;

  uart_baud_gen #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(OSR), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_clk_en(tx_clk_en), .rx_clk_en(rx_clk_en),
    .cfg_int(cfg_int), .cfg_frac(cfg_frac), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .tx_clk(tx_clk), .rx_clk(rx_clk),
    .rx_os_tick(rx_os_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic miss(input string nm, input longint at);
    checks++;
    errors++;
    $display("FAIL %s missed: strobe expected at cycle %0d was absent", nm, at);
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected: strobe at cycle %0d, none expected", nm, cyc);
  endtask

  // Monitor: compares each observed strobe with the oldest prediction.
  always @(negedge clk) begin
    if (mon_en) begin
      while (q_tx.size() > 0 && q_tx[0] < cyc) miss("tx_clk", q_tx.pop_front());
      while (q_os.size() > 0 && q_os[0] < cyc) miss("rx_os_tick", q_os.pop_front());
      while (q_rx.size() > 0 && q_rx[0] < cyc) miss("rx_clk", q_rx.pop_front());
      if (tx_clk) begin
        if (q_tx.size() == 0) unexp("tx_clk");
        else chk("tx_clk cycle", cyc, q_tx.pop_front());
      end
      if (rx_os_tick) begin
        if (q_os.size() == 0) unexp("rx_os_tick");
        else chk("rx_os_tick cycle", cyc, q_os.pop_front());
      end
      if (rx_clk) begin
        if (q_rx.size() == 0) unexp("rx_clk");
        else chk("rx_clk cycle", cyc, q_rx.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Period k (counted from enable) starts at S_k = k*I + floor(k*F/2^FRAC_W).
  // This follows from the fractional divisor: after k periods exactly
  // floor(k*F/2^FRAC_W) of them have been long.
  task automatic predict(input bit txe, input bit rxe, input longint c0, input int n);
    longint s, s_next;
    for (longint k = 0; ; k++) begin
      s      = k * m_int + ((k * m_frac) >> FRAC_W);
      s_next = (k + 1) * m_int + (((k + 1) * m_frac) >> FRAC_W);
      if (s >= n) break;
      if (txe && (k % OSR) == 0) q_tx.push_back(c0 + s);
      if (rxe && s_next - 1 < n) begin
        q_os.push_back(c0 + s_next - 1);
        if ((k % OSR) == OSR / 2 - 1) q_rx.push_back(c0 + s_next - 1);
      end
    end
  endtask

  // Idle load: pending visible for exactly one cycle, then applied.
  task automatic load(input int li, input int lf);
    cfg_int  = DIV_W'(li);
    cfg_frac = FRAC_W'(lf);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("idle_load pending_set", cfg_pending, 1);
    tick();
    chk("idle_load pending_clr", cfg_pending, 0);
    m_int  = (li < 2) ? 2 : li;
    m_frac = lf;
    m_pend = 1'b0;
  endtask

  // Enable channels for n cycles, optionally loading at cycle ld_at, then
  // drop both enables for one cycle.
  task automatic run(input bit txe, input bit rxe, input int n,
                     input bit do_ld, input int ld_at, input int li, input int lf);
    longint c0;
    tx_clk_en = txe;
    rx_clk_en = rxe;
    c0 = cyc;
    predict(txe, rxe, c0, n);
    for (int j = 0; j < n; j++) begin
      if (do_ld && j == ld_at) begin
        cfg_int  = DIV_W'(li);
        cfg_frac = FRAC_W'(lf);
        cfg_load = 1'b1;
      end
      tick();
      cfg_load = 1'b0;
    end
    if (do_ld) begin
      m_sh_int  = (li < 2) ? 2 : li;
      m_sh_frac = lf;
      m_pend    = 1'b1;
    end
    tx_clk_en = 1'b0;
    rx_clk_en = 1'b0;
    chk("tx_leftover", q_tx.size(), 0);
    chk("rx_os_leftover", q_os.size(), 0);
    chk("rx_clk_leftover", q_rx.size(), 0);
    q_tx.delete();
    q_os.delete();
    q_rx.delete();
    chk("run pending_hold", cfg_pending, m_pend);
    tick();
    if (m_pend) begin
      m_int  = m_sh_int;
      m_frac = m_sh_frac;
      m_pend = 1'b0;
    end
    chk("run pending_clr", cfg_pending, 0);
  endtask

  initial begin
    #(10 * 150_000);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int li, lf, n, ld_at;
    bit txe, rxe;

    // reset with tx enable high: strobes must stay low
    tx_clk_en = 1'b1;
    tick();
    tick();
    chk("rst tx_clk", tx_clk, 0);
    chk("rst rx_clk", rx_clk, 0);
    chk("rst rx_os_tick", rx_os_tick, 0);
    chk("rst cfg_pending", cfg_pending, 0);
    tx_clk_en = 1'b0;
    rst_n = 1'b1;
    m_int = DEF_I;
    m_frac = DEF_F;
    m_pend = 1'b0;
    tick();
    chk("idle tx_clk", tx_clk, 0);
    chk("idle cfg_pending", cfg_pending, 0);
    mon_en = 1'b1;

    // defaults: 5208-cycle bits, ticks 325/326
    run(1, 1, 5208 * 4 + 10, 0, 0, 0, 0);

    // idle load of 10/0
    load(10, 0);
    run(1, 1, 400, 0, 0, 0, 0);

    // load 20 while tx running: old spacing holds, then 320-cycle bits
    run(1, 0, 300, 1, 50, 20, 0);
    run(1, 1, 700, 0, 0, 0, 0);

    // clamps and fractional extremes
    load(0, 0);
    run(1, 1, 100, 0, 0, 0, 0);
    load(2, 15);
    run(1, 1, 200, 0, 0, 0, 0);
    load(1, 5);
    run(0, 1, 150, 0, 0, 0, 0);

    // load coinciding with a transfer: 7 applied, 9 left pending
    cfg_int = DIV_W'(7);
    cfg_frac = '0;
    cfg_load = 1'b1;
    tick();
    chk("coincide pending_a", cfg_pending, 1);
    cfg_int = DIV_W'(9);
    tick();
    cfg_load = 1'b0;
    chk("coincide pending_b", cfg_pending, 1);
    m_int = 7;
    m_frac = 0;
    m_sh_int = 9;
    m_sh_frac = 0;
    m_pend = 1'b1;
    run(1, 1, 120, 0, 0, 0, 0);
    run(1, 1, 200, 0, 0, 0, 0);

    // randomized divisors, enables and mid-run loads
    for (int it = 0; it < 16; it++) begin
      li  = int'($urandom_range(0, 30));
      lf  = int'($urandom_range(0, 15));
      txe = 1'($urandom_range(0, 1));
      rxe = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(40, 1200));
      if ($urandom_range(0, 1) == 1) begin
        load(li, lf);
        run(txe, rxe, n, 0, 0, 0, 0);
      end else begin
        if (!txe && !rxe) txe = 1'b1;
        ld_at = int'($urandom_range(0, n - 1));
        run(txe, rxe, n, 1, ld_at, li, lf);
      end
    end

    // asynchronous reset mid-bit with a pending load
    mon_en = 1'b0;
    tx_clk_en = 1'b1;
    rx_clk_en = 1'b1;
    repeat (700) tick();
    cfg_int = DIV_W'(5);
    cfg_frac = FRAC_W'(3);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    repeat (37) tick();
    chk("pre_rst pending", cfg_pending, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst tx_clk", tx_clk, 0);
    chk("async_rst rx_clk", rx_clk, 0);
    chk("async_rst rx_os_tick", rx_os_tick, 0);
    chk("async_rst cfg_pending", cfg_pending, 0);
    tx_clk_en = 1'b0;
    rx_clk_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_int = DEF_I;
    m_frac = DEF_F;
    m_pend = 1'b0;
    tick();
    chk("post_rst cfg_pending", cfg_pending, 0);
    mon_en = 1'b1;
    run(1, 1, 5208 * 2 + 10, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
